// File: rtl/dvbs2x_rx_symb_rate_decimator_pkg.sv
// Shared TX/RX symbol-rate definitions: selection encodings and decimation helpers.
package DVBS2X_SYMB_RATE_PKG;

  localparam int unsigned SYMB_RATE_SEL_NB = 2;
  localparam int unsigned NUM_SYMB_RATES   = 3;

  typedef enum logic [SYMB_RATE_SEL_NB-1:0] {
    SYMB_RATE_QUARTER = 2'd0,
    SYMB_RATE_HALF    = 2'd1,
    SYMB_RATE_FULL    = 2'd2
  } symb_rate_e;

  function automatic logic [1:0] symb_rate_decim_log2(input logic [SYMB_RATE_SEL_NB-1:0] sel);
    case (sel)
      SYMB_RATE_QUARTER: return 2'd2;
      SYMB_RATE_HALF:    return 2'd1;
      default:           return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dvbs2x_rx_symb_rate_decimator_if.sv
// AXI-Stream bundle carrying packed multi-channel sample beats.
interface AXIS_int #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned DEST_W = 1,
  parameter int unsigned USER_W = 1
);
  logic [DATA_W-1:0]         tdata;
  logic [(DATA_W+7)/8-1:0]   tkeep;
  logic [(DATA_W+7)/8-1:0]   tstrb;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;
  logic [ID_W-1:0]           tid;
  logic [DEST_W-1:0]         tdest;
  logic [USER_W-1:0]         tuser;

  modport Master (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
                  input  tready);
  modport Slave  (input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/dvbs2x_rx_symb_rate_avg_round.sv
// Boxcar average of 1, 2 or 4 samples with shift; rounding is convergent when
// DVBS2X_RX_SYMB_RATE_DECIM_CONV_ROUND_EN is defined, floor otherwise.
module dvbs2x_rx_symb_rate_avg_round #(
  parameter int unsigned NB = 16
) (
  input  logic signed [NB-1:0] x0,
  input  logic signed [NB-1:0] x1,
  input  logic signed [NB-1:0] x2,
  input  logic signed [NB-1:0] x3,
  input  logic [1:0]           shift,
  output logic signed [NB-1:0] y
);
  logic signed [NB+1:0] e0, e1, e2, e3, sum, q;
  logic                 unused_hi;

  assign e0 = x0;
  assign e1 = x1;
  assign e2 = x2;
  assign e3 = x3;

  always_comb begin
    case (shift)
      2'd0:    sum = e0;
      2'd1:    sum = e0 + e1;
      default: sum = e0 + e1 + e2 + e3;
    endcase
  end

  assign q = sum >>> shift;

`ifdef DVBS2X_RX_SYMB_RATE_DECIM_CONV_ROUND_EN
  logic                 up;
  logic signed [NB+1:0] rnd;

  // Round up above half; on exactly half only when the floor result is odd.
  always_comb begin
    case (shift)
      2'd0:    up = 1'b0;
      2'd1:    up = sum[0] & q[0];
      default: up = sum[1] & (sum[0] | q[0]);
    endcase
  end

  assign rnd       = q + $signed({{(NB+1){1'b0}}, up});
  assign y         = rnd[NB-1:0];
  assign unused_hi = ^rnd[NB+1:NB];
`else
  assign y         = q[NB-1:0];
  assign unused_hi = ^q[NB+1:NB];
`endif

endmodule

// File: rtl/dvbs2x_rx_symb_rate_decimator.sv
// RX symbol-rate decimator: per-beat boxcar average by 1/2/4 and repack into full beats.
// Optional convergent rounding via DVBS2X_RX_SYMB_RATE_DECIM_CONV_ROUND_EN.
module dvbs2x_rx_symb_rate_decimator
  import DVBS2X_SYMB_RATE_PKG::*;
#(
  parameter int unsigned N_PARALLEL = 8,
  parameter int unsigned N_CHANNELS = 2,
  parameter int unsigned NB         = 16
) (
  input  logic                        clk_sample,
  input  logic                        areset_sample_device,
  AXIS_int.Slave                      axis_in_dvbs2x,
  AXIS_int.Master                     axis_out_dvbs2x,
  input  logic [SYMB_RATE_SEL_NB-1:0] symb_rate_sel,
  output logic                        sel_invalid
);
  localparam int unsigned P1 = N_PARALLEL / 2;
  localparam int unsigned P2 = N_PARALLEL / 4;

  if (N_PARALLEL % 4 != 0) begin : g_bad_parallel
    $error("N_PARALLEL must be divisible by 4");
  end

  typedef logic signed [NB-1:0] samp_t;

  // Zero-padded to 4*N_PARALLEL so every quarter-rate tap index stays in range.
  samp_t in_x   [4*N_PARALLEL][N_CHANNELS];
  samp_t ax     [N_PARALLEL][N_CHANNELS][4];
  samp_t avg    [N_PARALLEL][N_CHANNELS];
  samp_t s1_avg [N_PARALLEL][N_CHANNELS];
  samp_t pack_q [N_PARALLEL][N_CHANNELS];
  samp_t merged [N_PARALLEL][N_CHANNELS];
  samp_t out_q  [N_PARALLEL][N_CHANNELS];

  logic [1:0] sel_q, phase, slot, dm1, cur_log2;
  logic [1:0] s1_slot, s1_log2;
  logic       s1_valid, s1_last, out_valid;
  logic       sel_ok, rate_change, accept;
  logic       unused_ok;

  assign cur_log2    = symb_rate_decim_log2(symb_rate_sel);
  assign dm1         = {cur_log2[1], cur_log2[1] | cur_log2[0]};
  assign sel_ok      = (symb_rate_sel != 2'd3);
  assign rate_change = (symb_rate_sel != sel_q);
  assign accept      = axis_in_dvbs2x.tvalid & sel_ok;
  assign slot        = rate_change ? 2'd0 : phase;

  always_comb begin
    in_x = '{default: '0};
    for (int unsigned p = 0; p < N_PARALLEL; p++)
      for (int unsigned c = 0; c < N_CHANNELS; c++)
        in_x[p][c] = axis_in_dvbs2x.tdata[NB*(N_CHANNELS*p+c) +: NB];
  end

  always_comb begin
    ax = '{default: '0};
    for (int unsigned k = 0; k < N_PARALLEL; k++)
      for (int unsigned c = 0; c < N_CHANNELS; c++)
        for (int unsigned j = 0; j < 4; j++)
          case (cur_log2)
            2'd0:    if (j == 0) ax[k][c][j] = in_x[k][c];
            2'd1:    if (j < 2)  ax[k][c][j] = in_x[2*k+j][c];
            default:             ax[k][c][j] = in_x[4*k+j][c];
          endcase
  end

  for (genvar gk = 0; gk < N_PARALLEL; gk++) begin : g_k
    for (genvar gc = 0; gc < N_CHANNELS; gc++) begin : g_c
      dvbs2x_rx_symb_rate_avg_round #(.NB(NB)) u_avg (
        .x0(ax[gk][gc][0]), .x1(ax[gk][gc][1]),
        .x2(ax[gk][gc][2]), .x3(ax[gk][gc][3]),
        .shift(cur_log2), .y(avg[gk][gc])
      );
    end
  end

  always_ff @(posedge clk_sample or posedge areset_sample_device) begin
    if (areset_sample_device) begin
      sel_q       <= SYMB_RATE_FULL;
      sel_invalid <= 1'b0;
      phase       <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_slot     <= '0;
      s1_log2     <= '0;
      s1_avg      <= '{default: '0};
    end else begin
      sel_q       <= symb_rate_sel;
      sel_invalid <= ~sel_ok;
      s1_valid    <= accept;
      if (!sel_ok)
        phase <= '0;
      else if (accept)
        phase <= (slot == dm1) ? 2'd0 : slot + 2'd1;
      else if (rate_change)
        phase <= '0;
      if (accept) begin
        s1_avg  <= avg;
        s1_slot <= slot;
        s1_log2 <= cur_log2;
        s1_last <= (slot == dm1);
      end
    end
  end

  // Stale slots left by a discarded partial frame are always overwritten before output.
  always_comb begin
    merged = pack_q;
    if (s1_valid)
      for (int unsigned m = 0; m < N_PARALLEL; m++)
        for (int unsigned c = 0; c < N_CHANNELS; c++)
          case (s1_log2)
            2'd0:    merged[m][c] = s1_avg[m][c];
            2'd1:    if (s1_slot == 2'(m / P1)) merged[m][c] = s1_avg[m % P1][c];
            default: if (s1_slot == 2'(m / P2)) merged[m][c] = s1_avg[m % P2][c];
          endcase
  end

  always_ff @(posedge clk_sample or posedge areset_sample_device) begin
    if (areset_sample_device) begin
      pack_q    <= '{default: '0};
      out_q     <= '{default: '0};
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid & s1_last;
      if (s1_valid)
        pack_q <= merged;
      if (s1_valid && s1_last)
        out_q <= merged;
    end
  end

  always_comb begin
    axis_out_dvbs2x.tdata = '0;
    for (int unsigned p = 0; p < N_PARALLEL; p++)
      for (int unsigned c = 0; c < N_CHANNELS; c++)
        axis_out_dvbs2x.tdata[NB*(N_CHANNELS*p+c) +: NB] = out_q[p][c];
  end

  assign axis_out_dvbs2x.tvalid = out_valid;
  assign axis_out_dvbs2x.tkeep  = '1;
  assign axis_out_dvbs2x.tstrb  = '1;
  assign axis_out_dvbs2x.tlast  = 1'b1;
  assign axis_out_dvbs2x.tid    = '0;
  assign axis_out_dvbs2x.tdest  = '0;
  assign axis_out_dvbs2x.tuser  = '0;
  assign axis_in_dvbs2x.tready  = 1'b1;

  assign unused_ok = ^{axis_in_dvbs2x.tlast, axis_in_dvbs2x.tid, axis_in_dvbs2x.tdest,
                       axis_in_dvbs2x.tuser, axis_in_dvbs2x.tkeep, axis_in_dvbs2x.tstrb,
                       axis_out_dvbs2x.tready};

endmodule

// File: tb/tb_dvbs2x_rx_symb_rate_decimator.sv
// Directed bench for the RX symbol-rate decimator with a frame scoreboard.
module tb_dvbs2x_rx_symb_rate_decimator;
  import DVBS2X_SYMB_RATE_PKG::*;

  localparam int NP = 8;
  localparam int NC = 2;
  localparam int NB = 16;
  localparam int W  = NP*NC*NB;
  localparam int KW = (W+7)/8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd2;
  logic       sel_invalid;

  AXIS_int #(.DATA_W(W)) in_if ();
  AXIS_int #(.DATA_W(W)) out_if ();

  dvbs2x_rx_symb_rate_decimator #(.N_PARALLEL(NP), .N_CHANNELS(NC), .NB(NB)) dut (
    .clk_sample(clk),
    .areset_sample_device(rst),
    .axis_in_dvbs2x(in_if.Slave),
    .axis_out_dvbs2x(out_if.Master),
    .symb_rate_sel(sel),
    .sel_invalid(sel_invalid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  int di [NP];
  int dq [NP];
  logic [W-1:0] exp_q [$];
  int           due_q [$];
  int           m_phase = 0;
  int           m_selq  = 2;
  logic [15:0]  mf [NP][NC];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mround(input int sum, input int l);
    int d, q, r;
    d = 1 << l;
    q = sum / d;
    if ((sum % d) != 0 && sum < 0) q = q - 1;
    r = sum - q*d;
`ifdef DVBS2X_RX_SYMB_RATE_DECIM_CONV_ROUND_EN
    if (2*r > d || (2*r == d && (q % 2) != 0)) q = q + 1;
`endif
    return 16'(q);
  endfunction

  function automatic logic [W-1:0] pack_in();
    logic [W-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      v[NB*(NC*p)   +: NB] = 16'(di[p]);
      v[NB*(NC*p+1) +: NB] = 16'(dq[p]);
    end
    return v;
  endfunction

  function automatic int samp(input int p, input int c);
    return (c == 0) ? di[p] : dq[p];
  endfunction

  task automatic send(input int s, input bit v);
    int l, d, per, sum;
    logic [W-1:0] f;
    in_if.tdata  = pack_in();
    in_if.tvalid = v;
    sel          = 2'(s);
    @(posedge clk);
    if (s != m_selq) m_phase = 0;
    m_selq = s;
    if (s != 3 && v) begin
      l   = (s == 0) ? 2 : (s == 1) ? 1 : 0;
      d   = 1 << l;
      per = NP / d;
      for (int k = 0; k < per; k++)
        for (int c = 0; c < NC; c++) begin
          sum = 0;
          for (int j = 0; j < d; j++) sum += samp(d*k+j, c);
          mf[m_phase*per+k][c] = mround(sum, l);
        end
      if (m_phase == d-1) begin
        f = '0;
        for (int m = 0; m < NP; m++)
          for (int c = 0; c < NC; c++)
            f[NB*(NC*m+c) +: NB] = mf[m][c];
        exp_q.push_back(f);
        due_q.push_back(ncyc + 2);
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_beat();
    for (int p = 0; p < NP; p++) begin
      di[p] = int'($urandom_range(0, 65535)) - 32768;
      dq[p] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // Output monitor: every cycle out of reset either a scheduled frame or nothing.
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (due_q.size() != 0 && due_q[0] == ncyc) begin
        chk("out_valid", W'(out_if.tvalid), W'(1'b1));
        chk("out_data", out_if.tdata, exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        chk("no_spurious_valid", W'(out_if.tvalid), W'(1'b0));
      end
    end
  end

  initial begin
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tkeep   = '1;
    in_if.tstrb   = '1;
    in_if.tlast   = 1'b0;
    in_if.tid     = '0;
    in_if.tdest   = '0;
    in_if.tuser   = '0;
    out_if.tready = 1'b0;
    for (int p = 0; p < NP; p++) begin di[p] = 0; dq[p] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", W'(out_if.tvalid), W'(1'b0));
    chk("rst_tdata", out_if.tdata, '0);
    chk("rst_sel_invalid", W'(sel_invalid), W'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    // FULL ramp pass-through, then random beats
    for (int p = 0; p < NP; p++) begin di[p] = p; dq[p] = -p; end
    send(2, 1);
    for (int p = 0; p < NP; p++) begin di[p] = p + 100; dq[p] = -p - 100; end
    send(2, 1);
    rand_beat(); send(2, 1);
    send(2, 0);
    send(2, 0);
    chk("tkeep", W'(out_if.tkeep), W'({KW{1'b1}}));
    chk("tlast", W'(out_if.tlast), W'(1'b1));
    chk("tid_tdest_tuser", W'({out_if.tid, out_if.tdest, out_if.tuser}), '0);

    // HALF: odd ramp over two beats
    for (int p = 0; p < NP; p++) begin di[p] = 2*p + 1;  dq[p] = -(2*p + 1); end
    send(1, 1);
    for (int p = 0; p < NP; p++) begin di[p] = 2*p + 17; dq[p] = -(2*p + 17); end
    send(1, 1);
    send(1, 0);
    send(1, 0);

    // HALF rounding pairs (1,2) (2,3) (-1,-2) plus odd/negative cases
    di = '{1, 2, 2, 3, -1, -2, 5, 7};
    dq = '{-3, 0, 32767, 32766, -32768, -32767, -5, -6};
    send(1, 1);
    di = '{-3, -4, 0, 1, 7, 8, -7, -8};
    dq = '{1, 2, 2, 3, -1, -2, 9, 10};
    send(1, 1);

    // HALF with input gaps
    rand_beat(); send(1, 1);
    send(1, 0);
    send(1, 0);
    rand_beat(); send(1, 1);

    // QUARTER extremes
    for (int p = 0; p < NP; p++) begin di[p] = 32767; dq[p] = 32767; end
    repeat (4) send(0, 1);
    for (int p = 0; p < NP; p++) begin di[p] = -32768; dq[p] = -32768; end
    repeat (4) send(0, 1);
    for (int b = 0; b < 4; b++) begin rand_beat(); send(0, 1); end

    // HALF -> QUARTER after one beat: partial frame dropped
    rand_beat(); send(1, 1);
    for (int b = 0; b < 4; b++) begin rand_beat(); send(0, 1); end
    send(0, 0);

    // Invalid selection for 10 beats, then back to FULL
    for (int b = 0; b < 10; b++) begin
      rand_beat();
      send(3, 1);
      chk("sel_invalid_hi", W'(sel_invalid), W'(1'b1));
    end
    rand_beat(); send(2, 1);
    chk("sel_invalid_lo", W'(sel_invalid), W'(1'b0));
    send(2, 0);
    send(2, 0);

    // Async reset in the middle of a QUARTER frame
    for (int p = 0; p < NP; p++) begin di[p] = -32768; dq[p] = 1234; end
    repeat (4) send(0, 1);
    send(0, 0);
    send(0, 0);
    rand_beat(); send(0, 1);
    rand_beat(); send(0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", W'(out_if.tvalid), W'(1'b0));
    chk("arst_tdata", out_if.tdata, '0);
    chk("arst_sel_invalid", W'(sel_invalid), W'(1'b0));
    chk("arst_no_inflight", W'(exp_q.size()), W'(0));
    m_phase = 0;
    m_selq  = 2;
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 4; b++) begin rand_beat(); send(0, 1); end

    repeat (5) send(0, 0);
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
